// File: rtl/pcie_gen3_pkg.sv
// Shared PCIe Gen3 128b/130b constants, descrambler FSM states and the serial LFSR step.
package pcie_gen3_pkg;

  localparam int BLK_BYTES = 16;
  localparam int CNT_W     = $clog2(BLK_BYTES);

  localparam logic [22:0] SEED_L0 = 23'h1DBFBC;
  localparam logic [22:0] SEED_L1 = 23'h0607BB;
  localparam logic [22:0] SEED_L2 = 23'h1EC760;
  localparam logic [22:0] SEED_L3 = 23'h18C0DB;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  localparam logic [7:0] OS_SKP_ID   = 8'hAA;
  localparam logic [7:0] OS_EIEOS_ID = 8'h00;
  localparam logic [7:0] OS_TS1_ID   = 8'h1E;
  localparam logic [7:0] OS_TS2_ID   = 8'h2D;
  localparam logic [7:0] OS_EIOS_ID  = 8'h66;
  localparam logic [7:0] OS_SDS_ID   = 8'hE1;
  localparam logic [7:0] OS_FTS_ID   = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_OS_SCR,
    ST_OS_SKP,
    ST_OS_EIEOS,
    ST_BAD
  } dsc_state_t;

  // One serial shift; the bit leaving position 22 is both the feed bit and the feedback.
  function automatic logic [22:0] lfsr_step(input logic [22:0] lr);
    logic fb;
    fb = lr[22];
    return {lr[21], lr[20] ^ fb, lr[19:16], lr[15] ^ fb, lr[14:8], lr[7] ^ fb,
            lr[6:5], lr[4] ^ fb, lr[3:2], lr[1] ^ fb, lr[0], fb};
  endfunction

  function automatic logic [22:0] lane_seed(input logic [1:0] lane);
    case (lane)
      2'd0:    return SEED_L0;
      2'd1:    return SEED_L1;
      2'd2:    return SEED_L2;
      default: return SEED_L3;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_23b_par8.sv
// Gen3 23-bit scrambler LFSR advanced eight serial steps per clk_1G, with per-lane seed load.
module lfsr_23b_par8 (
  input  logic        clk_1G,
  input  logic        rst_1G,
  input  logic        advance,
  input  logic        reseed,
  input  logic [1:0]  lanenum,
  output logic [7:0]  feed,
  output logic [22:0] state
);
  import pcie_gen3_pkg::*;

  logic [22:0] lr_adv;

  always_comb begin
    // NOTE: blocking assignments chain the eight steps inside one evaluation, so
    // each iteration sees the register value produced by the previous step.
    lr_adv = state;
    feed   = '0;
    for (int j = 0; j < 8; j++) begin
      feed[j] = lr_adv[22];
      lr_adv  = lfsr_step(lr_adv);
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
  always_ff @(posedge clk_1G) begin
    if (rst_1G || reseed) begin
      state <= lane_seed(lanenum);
    end else if (advance) begin
      state <= lr_adv;
    end
  end

endmodule

// File: rtl/descrambler_23b.sv
// PCIe Gen3 receive descrambler: one byte per clk_1G, 16-byte blocks, Gen3 ordered-set rules.
// Optional macro DSC_SCRAM_DIS_EN adds the scram_dis input that forces raw pass-through.
module descrambler_23b (
  input  logic       clk_1G,
  input  logic       rst_1G,
  input  logic [1:0] lanenum,
  input  logic       lfsr_init,
  input  logic       rx_valid,
  input  logic       rx_blk_start,
  input  logic [1:0] rx_sync_hdr,
  input  logic [7:0] rx_data,
`ifdef DSC_SCRAM_DIS_EN
  input  logic       scram_dis,
`endif
  output logic [7:0] dsc_data,
  output logic       dsc_valid,
  output logic       dsc_blk_start,
  output logic       dsc_is_os,
  output logic       dsc_err
);
  import pcie_gen3_pkg::*;

  dsc_state_t       state_q, hdr_state, byte_state;
  logic [CNT_W-1:0] cnt_q, idx;
  logic             start_blk, accept, align_err, mid_abort;
  logic             advance, reseed, is_os, raw, err, bypass;
  logic [7:0]       feed, out_data;
  logic [22:0]      lfsr_state_unused;

`ifdef DSC_SCRAM_DIS_EN
  assign bypass = scram_dis;
`else
  assign bypass = 1'b0;
`endif

  // Block type is decided from the header and, for ordered sets, the byte-0 identifier.
  always_comb begin
    hdr_state = ST_BAD;
    case (rx_sync_hdr)
      SH_DATA: hdr_state = ST_DATA;
      SH_OS: begin
        if (rx_data == OS_SKP_ID)        hdr_state = ST_OS_SKP;
        else if (rx_data == OS_EIEOS_ID) hdr_state = ST_OS_EIEOS;
        else                             hdr_state = ST_OS_SCR;
      end
      default: hdr_state = ST_BAD;
    endcase
  end

  assign start_blk  = rx_valid & rx_blk_start;
  assign byte_state = start_blk ? hdr_state : state_q;
  assign idx        = start_blk ? '0 : cnt_q;

  // cnt_q == 0 outside a block start means the previous block already delivered all 16 bytes.
  assign accept    = start_blk | (rx_valid & (state_q != ST_IDLE) & (cnt_q != '0));
  assign align_err = rx_valid & ~rx_blk_start & (state_q != ST_IDLE) & (cnt_q == '0);
  assign mid_abort = start_blk & (state_q != ST_IDLE) & (cnt_q != '0);

  assign advance = accept & (byte_state != ST_OS_SKP);
  assign reseed  = lfsr_init |
                   (accept & (byte_state == ST_OS_EIEOS) & (idx == CNT_W'(BLK_BYTES - 1)));

  assign is_os    = byte_state inside {ST_OS_SCR, ST_OS_SKP, ST_OS_EIEOS};
  assign raw      = bypass | ((byte_state != ST_DATA) &&
                              !((byte_state == ST_OS_SCR) && (idx != '0)));
  assign out_data = raw ? rx_data : (rx_data ^ feed);
  assign err      = mid_abort | (byte_state == ST_BAD);

  lfsr_23b_par8 u_lfsr (
    .clk_1G  (clk_1G),
    .rst_1G  (rst_1G),
    .advance (advance),
    .reseed  (reseed),
    .lanenum (lanenum),
    .feed    (feed),
    .state   (lfsr_state_unused)
  );

  always_ff @(posedge clk_1G) begin
    if (rst_1G || lfsr_init) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dsc_data      <= '0;
      dsc_valid     <= 1'b0;
      dsc_blk_start <= 1'b0;
      dsc_is_os     <= 1'b0;
      dsc_err       <= 1'b0;
    end else begin
      dsc_valid     <= accept;
      dsc_data      <= accept ? out_data : '0;
      dsc_blk_start <= accept & (idx == '0);
      dsc_is_os     <= accept & is_os;
      dsc_err       <= (accept & err) | align_err;
      if (accept) begin
        state_q <= byte_state;
        cnt_q   <= idx + 1'b1;
      end else if (align_err) begin
        state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/descrambler_23b.md
Name: descrambler_23b

Overview:
Receive-side descrambler for the PCIe 3.0 128b/130b logical physical layer. It processes one byte per clk_1G, in 16-byte blocks tagged with a 2-bit sync header. It regenerates the per-lane Gen3 LFSR sequence, XORs it onto data-block and scrambled ordered-set bytes, and applies the Gen3 ordered-set rules: SKP freezes the LFSR, EIEOS re-seeds it, and the OS identifier byte is passed unscrambled. It sits between block alignment/sync-header stripping and the receive byte/lane deskew logic.

Parameters:
- BLK_BYTES, 16, payload bytes per 130b block. Fixed at 16; this sets the counter width.
- SEED_L0..SEED_L3, 23'h1DBFBC / 23'h0607BB / 23'h1EC760 / 23'h18C0DB, per-lane LFSR seeds.

Ports:
- clk_1G  in  1  byte clock.
- rst_1G  in  1  reset; synchronous, active-high.
- lanenum  in  2  lane index; selects the seed.
- lfsr_init  in  1  synchronous re-seed request from the control block; active-high.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_blk_start  in  1  rx_data is byte 0 of a block; rx_sync_hdr is valid on this cycle.
- rx_sync_hdr  in  2  2'b10 = data block, 2'b01 = ordered-set block, other values invalid.
- rx_data  in  8  received byte, bit 0 first on the wire.
- dsc_data  out  8  descrambled byte.
- dsc_valid  out  1  dsc_data is valid.
- dsc_blk_start  out  1  dsc_data is byte 0 of a block.
- dsc_is_os  out  1  the current block is an ordered set.
- dsc_err  out  1  invalid sync header or alignment error.

Behaviour:
- LFSR serial step, with fb = LR[22]:
  - LR' = {LR[21], LR[20]^fb, LR[19:16], LR[15]^fb, LR[14:8], LR[7]^fb, LR[6:5], LR[4]^fb, LR[3:2], LR[1]^fb, LR[0], fb}.
  - The feed bit for step j is fb; it XORs data bit j (j = 0..7, LSB first).
- Per byte: 8 serial steps unrolled combinationally; LR and feed are updated in one clk_1G cycle.
- Reset or lfsr_init: LR loads the seed selected by lanenum; FSM goes to IDLE; all outputs are 0. lfsr_init has priority over an advance in the same cycle.
- rx_valid low: no LFSR advance, no counter change, dsc_valid = 0 on the next cycle.
- Latency: exactly 1 cycle, rx to dsc. All outputs are registered.
- Byte counter: 4 bits, cleared on rx_blk_start, incremented on each valid byte, wraps 15 to 0. A wrap to 0 with no rx_blk_start on the next valid byte is an alignment error.
- FSM states:
  - IDLE: waits for rx_valid & rx_blk_start.
  - DATA: hdr 10. All 16 bytes descrambled; LFSR advances.
  - OS_SCR: hdr 01 with ID byte not 8'hAA and not 8'h00 (TS1 1E, TS2 2D, EIOS 66, SDS E1, FTS 55). Byte 0 is passed raw and the LFSR still advances; bytes 1-15 are descrambled.
  - OS_SKP: ID 8'hAA. All bytes passed raw; LFSR frozen for the whole block.
  - OS_EIEOS: ID 8'h00. All bytes passed raw; LFSR advances; LR re-seeds on byte 15.
  - BAD: hdr 00/11. Bytes passed raw; LFSR advances; dsc_err = 1 on every byte of the block.
- The ID decision uses the byte-0 rx_data combinationally, so byte 0 itself is handled per its state (always raw for OS).
- At counter 15, the next rx_blk_start selects the next state. A valid byte with no rx_blk_start goes to IDLE, raises a 1-cycle dsc_err, and the byte is dropped (dsc_valid = 0).
- rx_blk_start mid-block (counter ≠ 0): abort the current block, raise dsc_err on that output byte, and start the new block normally. The LFSR is not rewound.
- dsc_is_os is held for all 16 output bytes of an OS block.

Optional Feature:
- Macro DSC_SCRAM_DIS_EN adds input port scram_dis (1 bit), driven by the training "disable scrambling" bit.
- With the macro, when scram_dis = 1:
  - every byte is passed raw;
  - the LFSR still advances and re-seeds per the rules above;
  - FSM and error behaviour are unchanged.
- Without the macro, the port is absent and descrambling is always active.

Decomposition:
- Package pcie_gen3_pkg holds:
  - the lane seed constants;
  - sync header codes SH_DATA = 2'b10 and SH_OS = 2'b01;
  - OS IDs: SKP AA, EIEOS 00, TS1 1E, TS2 2D, EIOS 66, SDS E1, FTS 55;
  - the FSM state enum;
  - the serial LFSR step function.
- Sub-module lfsr_23b_par8 holds the LFSR register, seed mux, and 8-step unroll. Its inputs are advance, reseed, and lanenum; its outputs are feed[7:0] and state[22:0].

Test Plan:
- Lanes 0-3 after reset, one data block (hdr 10) of 16 bytes, each byte equal to the golden-model feed -> dsc_data = 8'h00 for all 16 bytes; dsc_blk_start on byte 0 only; latency 1 cycle.
- Data block, then a SKP block (hdr 01, 16 × 8'hAA), then a data block -> SKP bytes output as 8'hAA. LR after SKP equals LR before it, so the second data block descrambles per the golden model.
- EIEOS block (hdr 01, pattern 00,FF repeated) mid-stream -> bytes passed raw, dsc_is_os = 1; LR = lane seed after byte 15, so the next data block matches the golden model from the seed.
- TS1 block (ID 1E, 15 scrambled bytes) -> byte 0 = 8'h1E raw; bytes 1-15 are descrambled with the feed offset by 1 byte.
- Header 2'b11 block -> dsc_err = 1 on all 16 bytes. rx_blk_start at counter 7 -> dsc_err pulse, then the new block decodes correctly.
- rx_valid toggled 1/0 and lfsr_init asserted mid-block -> no advance on gaps. After lfsr_init, output matches the seed stream; dsc_valid mirrors rx_valid with 1-cycle delay.
